// File: rtl/fft_peak_detect.sv
// fft_peak_detect
//    Power / peak detector placed directly after the streaming FFT.
//    Every accepted bin gets power = re^2 + im^2 through a 3-stage pipeline.
//    Each well-formed frame reports the highest-power bin of the
//    positive-frequency half. Frames whose sop/eop framing disagrees with N
//    raise a one-cycle frame_err and are dropped.
//
// Ports
//    clk, rst_n                  clock, synchronous active-low reset
//    in_valid/in_sop/in_eop      FFT output framing (no backpressure)
//    in_real, in_imag            signed DW-bit bin value
//    pwr_valid/pwr_out/pwr_idx   per-bin power stream, 3 cycles after input
//    peak_valid/peak_idx/peak_pwr  per-frame peak result (one-cycle pulse)
//    frame_err                   one-cycle pulse, 1 cycle after the bad input
//    frame_cnt                   good-frame counter, wraps
//
// state  | meaning
// -------+-----------------------------------------------------------------
// IDLE   | waiting for an sop sample
// ACCUM  | inside a frame; with drain_q set the eop has been taken and the
//        | input side behaves like IDLE while the frame leaves the pipeline
// REPORT | one cycle, peak_valid is high; an sop here starts the next frame
module fft_peak_detect #(
   parameter int N       = 512,
   parameter int DW      = 32,
   parameter int IW      = 10,
   parameter int SKIP_DC = 1
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 in_valid,
   input  logic                 in_sop,
   input  logic                 in_eop,
   input  logic signed [DW-1:0] in_real,
   input  logic signed [DW-1:0] in_imag,
   output logic                 pwr_valid,
   output logic [2*DW:0]        pwr_out,
   output logic [IW-1:0]        pwr_idx,
   output logic                 peak_valid,
   output logic [IW-1:0]        peak_idx,
   output logic [2*DW:0]        peak_pwr,
   output logic                 frame_err,
   output logic [15:0]          frame_cnt
);

   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_ACCUM  = 2'd1;
   localparam logic [1:0] ST_REPORT = 2'd2;

   localparam logic [IW:0]   CNT_ONE   = (IW+1)'(1);
   localparam logic [IW:0]   CNT_LAST  = (IW+1)'(N-1);
   localparam logic [IW:0]   CNT_FULL  = (IW+1)'(N);
   localparam logic [IW-1:0] IDX_FIRST = (SKIP_DC != 0) ? IW'(1) : '0;
   localparam logic [IW-1:0] IDX_HALF  = IW'(N/2);

   // input-side framing FSM
   logic [1:0]  st_q, st_d;
   logic [IW:0] cnt_q, cnt_d;       // index the next in-frame sample gets
   logic        drain_q, drain_d;
   logic        err_q, err_d;
   logic        open_frame;
   logic        take, t_sop, t_eop;
   logic        rpt;

   // power pipeline
   logic                 s1_v_q, s1_sop_q, s1_eop_q;
   logic signed [DW-1:0] s1_re_q, s1_im_q;
   logic [IW-1:0]        s1_idx_q;
   logic                 s2_v_q, s2_sop_q, s2_eop_q;
   logic [2*DW-1:0]      s2_re2_q, s2_im2_q;
   logic [IW-1:0]        s2_idx_q;
   logic                 s3_v_q, s3_sop_q, s3_eop_q;
   logic [2*DW:0]        s3_pwr_q;
   logic [IW-1:0]        s3_idx_q;
   logic signed [2*DW-1:0] re_x, im_x;

   // peak search
   logic [2*DW:0]   acc_pwr_q, base_pwr, new_pwr;
   logic [IW-1:0]   acc_idx_q, base_idx, new_idx;
   logic            cand;

   logic            pk_v_q;
   logic [IW-1:0]   pk_idx_q;
   logic [2*DW:0]   pk_pwr_q;
   logic [15:0]     fcnt_q;

   // only good-eop samples carry s3_eop_q, so this is the report trigger
   assign rpt = s3_v_q & s3_eop_q;

   always_comb begin
      st_d       = st_q;
      cnt_d      = cnt_q;
      drain_d    = drain_q;
      err_d      = 1'b0;
      take       = 1'b0;
      t_sop      = 1'b0;
      t_eop      = 1'b0;
      open_frame = (st_q == ST_ACCUM) && !drain_q;
      if (in_valid) begin
         if (!open_frame) begin
            if (in_sop && in_eop) begin
               err_d = 1'b1;
            end else if (in_sop) begin
               take    = 1'b1;
               t_sop   = 1'b1;
               cnt_d   = CNT_ONE;
               st_d    = ST_ACCUM;
               drain_d = 1'b0;
            end
         end else if (in_sop) begin
            err_d = 1'b1;
            if (in_eop) begin
               st_d = ST_IDLE;
            end else begin
               take  = 1'b1;
               t_sop = 1'b1;
               cnt_d = CNT_ONE;
            end
         end else if (cnt_q == CNT_FULL) begin
            // N bins already taken without eop: drop this one
            err_d = 1'b1;
            st_d  = ST_IDLE;
         end else if (in_eop) begin
            if (cnt_q == CNT_LAST) begin
               take    = 1'b1;
               t_eop   = 1'b1;
               drain_d = 1'b1;
            end else begin
               err_d = 1'b1;
               st_d  = ST_IDLE;
            end
         end else begin
            take  = 1'b1;
            cnt_d = cnt_q + 1'b1;
         end
      end
      if (st_q == ST_REPORT && st_d == ST_REPORT) begin
         st_d = ST_IDLE;
      end
      // a new frame that already started keeps the FSM in ACCUM
      if (rpt && st_d == ST_ACCUM && drain_d) begin
         st_d    = ST_REPORT;
         drain_d = 1'b0;
      end
   end

   always_comb begin
      re_x = (2*DW)'(s1_re_q);
      im_x = (2*DW)'(s1_im_q);
   end

   always_comb begin
      base_pwr = s3_sop_q ? '0 : acc_pwr_q;
      base_idx = s3_sop_q ? IDX_FIRST : acc_idx_q;
      cand     = ((SKIP_DC == 0) || (s3_idx_q != '0)) && (s3_idx_q < IDX_HALF);
      new_pwr  = base_pwr;
      new_idx  = base_idx;
      if (cand && (s3_pwr_q > base_pwr)) begin
         new_pwr = s3_pwr_q;
         new_idx = s3_idx_q;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         st_q      <= ST_IDLE;
         cnt_q     <= '0;
         drain_q   <= 1'b0;
         err_q     <= 1'b0;
         s1_v_q    <= 1'b0;
         s1_sop_q  <= 1'b0;
         s1_eop_q  <= 1'b0;
         s1_re_q   <= '0;
         s1_im_q   <= '0;
         s1_idx_q  <= '0;
         s2_v_q    <= 1'b0;
         s2_sop_q  <= 1'b0;
         s2_eop_q  <= 1'b0;
         s2_re2_q  <= '0;
         s2_im2_q  <= '0;
         s2_idx_q  <= '0;
         s3_v_q    <= 1'b0;
         s3_sop_q  <= 1'b0;
         s3_eop_q  <= 1'b0;
         s3_pwr_q  <= '0;
         s3_idx_q  <= '0;
         acc_pwr_q <= '0;
         acc_idx_q <= '0;
         pk_v_q    <= 1'b0;
         pk_idx_q  <= '0;
         pk_pwr_q  <= '0;
         fcnt_q    <= '0;
      end else begin
         st_q     <= st_d;
         cnt_q    <= cnt_d;
         drain_q  <= drain_d;
         err_q    <= err_d;

         s1_v_q   <= take;
         s1_sop_q <= take & t_sop;
         s1_eop_q <= take & t_eop;
         s1_re_q  <= in_real;
         s1_im_q  <= in_imag;
         s1_idx_q <= t_sop ? '0 : cnt_q[IW-1:0];

         s2_v_q   <= s1_v_q;
         s2_sop_q <= s1_sop_q;
         s2_eop_q <= s1_eop_q;
         s2_re2_q <= re_x * re_x;
         s2_im2_q <= im_x * im_x;
         s2_idx_q <= s1_idx_q;

         s3_v_q   <= s2_v_q;
         s3_sop_q <= s2_sop_q;
         s3_eop_q <= s2_eop_q;
         s3_pwr_q <= {1'b0, s2_re2_q} + {1'b0, s2_im2_q};
         s3_idx_q <= s2_idx_q;

         if (s3_v_q) begin
            acc_pwr_q <= new_pwr;
            acc_idx_q <= new_idx;
         end
         pk_v_q <= rpt;
         if (rpt) begin
            pk_idx_q <= new_idx;
            pk_pwr_q <= new_pwr;
            fcnt_q   <= fcnt_q + 16'd1;
         end
      end
   end

   assign pwr_valid  = s3_v_q;
   assign pwr_out    = s3_pwr_q;
   assign pwr_idx    = s3_idx_q;
   assign peak_valid = pk_v_q;
   assign peak_idx   = pk_idx_q;
   assign peak_pwr   = pk_pwr_q;
   assign frame_err  = err_q;
   assign frame_cnt  = fcnt_q;

endmodule

// File: tb/tb_fft_peak_detect.sv
module tb_fft_peak_detect;

   localparam int N       = 512;
   localparam int DW      = 32;
   localparam int IW      = 10;
   localparam int SKIP_DC = 1;
   localparam longint MINV = -64'sd2147483648;

   logic clk = 1'b0;
   logic rst_n;
   logic in_valid, in_sop, in_eop;
   logic signed [DW-1:0] in_real, in_imag;
   logic pwr_valid, peak_valid, frame_err;
   logic [2*DW:0] pwr_out, peak_pwr;
   logic [IW-1:0] pwr_idx, peak_idx;
   logic [15:0] frame_cnt;

   always #5 clk = ~clk;

   fft_peak_detect #(.N(N), .DW(DW), .IW(IW), .SKIP_DC(SKIP_DC)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_sop(in_sop),
      .in_eop(in_eop), .in_real(in_real), .in_imag(in_imag),
      .pwr_valid(pwr_valid), .pwr_out(pwr_out), .pwr_idx(pwr_idx),
      .peak_valid(peak_valid), .peak_idx(peak_idx), .peak_pwr(peak_pwr),
      .frame_err(frame_err), .frame_cnt(frame_cnt)
   );

   typedef struct { time t; int idx; logic [64:0] p; } pwr_exp_t;
   typedef struct { time t; int idx; logic [64:0] p; int cnt; } peak_exp_t;
   typedef struct {
      int b0; longint r0; longint i0;
      int b1; longint r1; int b2; longint r2; int b3; longint r3;
      int last; int gap; bit exp_peak; int exp_idx; logic [64:0] exp_pwr;
   } vec_t;

   pwr_exp_t  pq[$];
   peak_exp_t kq[$];
   time       eq[$];
   longint    fre[N];
   longint    fim[N];
   int        nchk = 0, nerr = 0;
   int        exp_cnt = 0;
   int        pk_seen = 0, err_seen = 0;
   int        last_idx = 0;
   logic [64:0] last_pwr = '0;
   vec_t      vec[9];

   function automatic void chk(string nm, logic [64:0] act, logic [64:0] exp);
      nchk++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s actual=%0d required=%0d at %0t", nm, act, exp, $time);
      end
   endfunction

   // power of one bin, straight from the definition re^2 + im^2
   function automatic logic [64:0] pw(longint r, longint i);
      logic signed [64:0] a, b;
      logic [64:0] s;
      a = 65'(r);
      b = 65'(i);
      s = 65'(a * a);
      s = s + 65'(b * b);
      return s;
   endfunction

   // lowest-index maximum over the candidate bins, zero-power default
   function automatic void model_peak(output int idx, output logic [64:0] p);
      idx = SKIP_DC;
      p   = '0;
      for (int b = SKIP_DC; b < N/2; b++) begin
         if (pw(fre[b], fim[b]) > p) begin
            p   = pw(fre[b], fim[b]);
            idx = b;
         end
      end
   endfunction

   function automatic vec_t mk(int b0, longint r0, longint i0, int b1, longint r1,
                               int b2, longint r2, int b3, longint r3, int last,
                               int gap, bit ep, int ei, logic [64:0] epw);
      vec_t v;
      v.b0 = b0; v.r0 = r0; v.i0 = i0; v.b1 = b1; v.r1 = r1;
      v.b2 = b2; v.r2 = r2; v.b3 = b3; v.r3 = r3;
      v.last = last; v.gap = gap; v.exp_peak = ep; v.exp_idx = ei; v.exp_pwr = epw;
      return v;
   endfunction

   always @(negedge clk) begin
      pwr_exp_t  pe;
      peak_exp_t ke;
      if (pwr_valid === 1'b1) begin
         if (pq.size() == 0) chk("pwr_unexpected", 65'd1, 65'd0);
         else begin
            pe = pq.pop_front();
            chk("pwr_latency", 65'($time - pe.t), 65'd30);
            chk("pwr_idx", 65'(pwr_idx), 65'(pe.idx));
            chk("pwr_out", pwr_out, pe.p);
         end
      end
      if (peak_valid === 1'b1) begin
         pk_seen++;
         last_idx = int'(peak_idx);
         last_pwr = peak_pwr;
         if (kq.size() == 0) chk("peak_unexpected", 65'd1, 65'd0);
         else begin
            ke = kq.pop_front();
            chk("peak_latency", 65'($time), 65'(ke.t));
            chk("peak_idx", 65'(peak_idx), 65'(ke.idx));
            chk("peak_pwr", peak_pwr, ke.p);
            chk("frame_cnt", 65'(frame_cnt), 65'(ke.cnt));
         end
      end
      if (frame_err === 1'b1) begin
         err_seen++;
         if (eq.size() == 0) chk("err_unexpected", 65'd1, 65'd0);
         else chk("err_latency", 65'($time - eq.pop_front()), 65'd10);
      end
   end

   task automatic drive(input bit v, input bit s, input bit e, input longint r, input longint i);
      @(negedge clk);
      in_valid = v; in_sop = s; in_eop = e;
      in_real = DW'(r); in_imag = DW'(i);
   endtask

   task automatic idle(input int n);
      repeat (n) drive(1'b0, 1'b0, 1'b0, 0, 0);
   endtask

   task automatic clear_frame();
      for (int b = 0; b < N; b++) begin fre[b] = 0; fim[b] = 0; end
   endtask

   task automatic push_pwr(input int b);
      pwr_exp_t pe;
      pe.t = $time; pe.idx = b; pe.p = pw(fre[b], fim[b]);
      pq.push_back(pe);
   endtask

   task automatic send_frame(input int last, input int gap, input bit restart, input int tail);
      peak_exp_t ke;
      for (int b = 0; b <= last; b++) begin
         while (gap > 0 && $urandom_range(99) < gap) drive(1'b0, 1'b0, 1'b0, 0, 0);
         drive(1'b1, b == 0, b == last, fre[b], fim[b]);
         if (b == 0 && restart) eq.push_back($time);
         if (b == last && last != N-1) eq.push_back($time);
         else push_pwr(b);
      end
      if (last == N-1) begin
         exp_cnt = (exp_cnt + 1) % 65536;
         model_peak(ke.idx, ke.p);
         ke.t = $time + 40;
         ke.cnt = exp_cnt;
         kq.push_back(ke);
      end
      idle(tail);
   endtask

   task automatic check_zero(input string nm);
      chk({nm, "_pwr_valid"}, 65'(pwr_valid), 65'd0);
      chk({nm, "_pwr_out"}, pwr_out, 65'd0);
      chk({nm, "_pwr_idx"}, 65'(pwr_idx), 65'd0);
      chk({nm, "_peak_valid"}, 65'(peak_valid), 65'd0);
      chk({nm, "_peak_idx"}, 65'(peak_idx), 65'd0);
      chk({nm, "_peak_pwr"}, peak_pwr, 65'd0);
      chk({nm, "_frame_err"}, 65'(frame_err), 65'd0);
      chk({nm, "_frame_cnt"}, 65'(frame_cnt), 65'd0);
   endtask

   initial begin
      int pk0, er0;
      rst_n = 1'b0; in_valid = 1'b0; in_sop = 1'b0; in_eop = 1'b0;
      in_real = '0; in_imag = '0;
      repeat (3) @(negedge clk);
      check_zero("reset");
      rst_n = 1'b1;

      vec[0] = mk(37, 1000, 0, -1, 0, -1, 0, -1, 0, N-1, 0, 1'b1, 37, 65'd1000000);
      vec[1] = mk(10, 50, 0, 200, 50, 0, 100000, 300, 100000, N-1, 0, 1'b1, 10, 65'd2500);
      vec[2] = mk(5, MINV, MINV, -1, 0, -1, 0, -1, 0, N-1, 0, 1'b1, 5, 65'd9223372036854775808);
      vec[3] = mk(100, 7, 0, -1, 0, -1, 0, -1, 0, 300, 0, 1'b0, 0, 65'd0);
      vec[4] = mk(100, 123, 0, -1, 0, -1, 0, -1, 0, N-1, 0, 1'b1, 100, 65'd15129);
      vec[5] = mk(255, -3000, 0, -1, 0, -1, 0, -1, 0, N-1, 50, 1'b1, 255, 65'd9000000);
      vec[6] = mk(-1, 0, 0, -1, 0, -1, 0, -1, 0, N-1, 0, 1'b1, 1, 65'd0);
      vec[7] = mk(255, 400, 0, 256, 500, 0, 999, -1, 0, N-1, 0, 1'b1, 255, 65'd160000);
      vec[8] = mk(1, 2, 0, 255, -2, -1, 0, -1, 0, N-1, 0, 1'b1, 1, 65'd4);

      for (int k = 0; k < 9; k++) begin
         clear_frame();
         if (vec[k].b0 >= 0) begin fre[vec[k].b0] = vec[k].r0; fim[vec[k].b0] = vec[k].i0; end
         if (vec[k].b1 >= 0) fre[vec[k].b1] = vec[k].r1;
         if (vec[k].b2 >= 0) fre[vec[k].b2] = vec[k].r2;
         if (vec[k].b3 >= 0) fre[vec[k].b3] = vec[k].r3;
         pk0 = pk_seen; er0 = err_seen;
         send_frame(vec[k].last, vec[k].gap, 1'b0, 8);
         if (vec[k].exp_peak) begin
            chk("tbl_peak_count", 65'(pk_seen - pk0), 65'd1);
            chk("tbl_peak_idx", 65'(last_idx), 65'(vec[k].exp_idx));
            chk("tbl_peak_pwr", last_pwr, vec[k].exp_pwr);
         end else begin
            chk("tbl_no_peak", 65'(pk_seen - pk0), 65'd0);
            chk("tbl_err_count", 65'(err_seen - er0), 65'd1);
         end
         chk("tbl_frame_cnt", 65'(frame_cnt), 65'(exp_cnt));
      end

      // reset in the middle of a frame
      clear_frame();
      fre[100] = 555;
      pk0 = pk_seen;
      for (int b = 0; b < 250; b++) begin
         drive(1'b1, b == 0, 1'b0, fre[b], fim[b]);
         push_pwr(b);
      end
      @(negedge clk);
      rst_n = 1'b0; in_valid = 1'b1; in_sop = 1'b0; in_eop = 1'b0;
      @(negedge clk);
      rst_n = 1'b1; in_valid = 1'b0;
      pq.delete(); kq.delete(); eq.delete();
      exp_cnt = 0;
      check_zero("rst_mid");
      idle(8);
      chk("rst_no_peak", 65'(pk_seen - pk0), 65'd0);
      clear_frame();
      fre[9] = 11;
      send_frame(N-1, 0, 1'b0, 8);
      chk("rst_frame_cnt", 65'(frame_cnt), 65'd1);
      chk("rst_peak_idx", 65'(last_idx), 65'd9);

      // sop in the middle of a frame restarts it
      clear_frame();
      fre[40] = 77;
      for (int b = 0; b < 20; b++) begin
         drive(1'b1, b == 0, 1'b0, fre[b], fim[b]);
         push_pwr(b);
      end
      er0 = err_seen;
      send_frame(N-1, 0, 1'b1, 8);
      chk("restart_err", 65'(err_seen - er0), 65'd1);
      chk("restart_idx", 65'(last_idx), 65'd40);

      // N bins without eop, then one extra sample
      clear_frame();
      fre[3] = 5;
      pk0 = pk_seen; er0 = err_seen;
      for (int b = 0; b < N; b++) begin
         drive(1'b1, b == 0, 1'b0, fre[b], fim[b]);
         push_pwr(b);
      end
      drive(1'b1, 1'b0, 1'b0, 9, 9);
      eq.push_back($time);
      idle(8);
      chk("overrun_no_peak", 65'(pk_seen - pk0), 65'd0);
      chk("overrun_err", 65'(err_seen - er0), 65'd1);

      // stray samples in IDLE, then sop+eop together
      er0 = err_seen;
      repeat (3) drive(1'b1, 1'b0, 1'b0, 5, 5);
      drive(1'b1, 1'b1, 1'b1, 5, 5);
      eq.push_back($time);
      idle(6);
      chk("sop_eop_err", 65'(err_seen - er0), 65'd1);

      // back-to-back frames with no idle between them
      clear_frame();
      fre[60] = 1000;
      pk0 = pk_seen;
      send_frame(N-1, 0, 1'b0, 0);
      clear_frame();
      fre[61] = 2000;
      send_frame(N-1, 0, 1'b0, 8);
      chk("b2b_peaks", 65'(pk_seen - pk0), 65'd2);
      chk("b2b_idx", 65'(last_idx), 65'd61);

      // randomized frames against the reference model
      for (int f = 0; f < 3; f++) begin
         for (int b = 0; b < N; b++) begin
            fre[b] = longint'(int'($urandom));
            fim[b] = longint'(int'($urandom));
         end
         send_frame(N-1, 25, 1'b0, 6);
      end

      idle(10);
      chk("pwr_missing", 65'(pq.size()), 65'd0);
      chk("peak_missing", 65'(kq.size()), 65'd0);
      chk("err_missing", 65'(eq.size()), 65'd0);
      $display("Result: errors=%0d of %0d checks", nerr, nchk);
      $finish;
   end

endmodule
